// File: rtl/pe_filter_loader.sv
// pe_filter_loader
//   Packs a valid/ready stream of IN_WIDTH filter beats into RAM_WIDTH words
//   and broadcasts them as write requests to the per-PE filter RAMs. One
//   command (i_start) walks every PE, every filter and num_words addresses,
//   then pulses o_done.
//
// Ports
//   clock, reset        sole clock, asynchronous active-high reset
//   i_start             command strobe, only sampled in IDLE
//   i_base_addr         first RAM address written per filter
//   i_num_words         words per filter (1..RAM_DEPTH, clamped if illegal)
//   i_data/i_valid      input beat stream
//   o_ready             beat accepted when i_valid && o_ready
//   o_wr_*              broadcast write request, qualify fields with enable
//   o_busy              command in progress
//   o_done              one-cycle pulse, one cycle after the final enable
//
// State table
//   state  | meaning
//   S_IDLE | waiting for i_start, stream not accepted
//   S_LOAD | accepting beats, issuing a write per completed word
//   S_LAST | final word's write is on the bus, stream closed
//   S_DONE | o_done pulse, busy dropped, back to IDLE next cycle
module pe_filter_loader #(
  parameter int NUM_PES        = 4,
  parameter int NUM_FILTERS    = 4,
  parameter int RAM_DEPTH      = 512,
  parameter int RAM_ADDR_WIDTH = 9,
  parameter int RAM_WIDTH      = 256,
  parameter int IN_WIDTH       = 64,
  localparam int PE_W          = (NUM_PES > 1) ? $clog2(NUM_PES) : 1,
  localparam int F_W           = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic [RAM_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [RAM_ADDR_WIDTH:0]   i_num_words,
  input  logic [IN_WIDTH-1:0]       i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_wr_enable,
  output logic [PE_W-1:0]           o_wr_pe_id,
  output logic [F_W-1:0]            o_wr_filter_id,
  output logic [RAM_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [RAM_WIDTH-1:0]      o_wr_data,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int BEATS  = RAM_WIDTH / IN_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]       LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [F_W-1:0]          LAST_FILTER = F_W'(NUM_FILTERS - 1);
  localparam logic [PE_W-1:0]         LAST_PE     = PE_W'(NUM_PES - 1);
  localparam logic [RAM_ADDR_WIDTH:0] NW_ONE      = (RAM_ADDR_WIDTH + 1)'(1);
  localparam logic [RAM_ADDR_WIDTH:0] NW_DEPTH    = (RAM_ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RAM_ADDR_WIDTH-1:0] r_base;
  logic [RAM_ADDR_WIDTH-1:0] r_last_off;
  logic [RAM_ADDR_WIDTH-1:0] r_offset;
  logic [F_W-1:0]            r_filter;
  logic [PE_W-1:0]           r_pe;
  logic [BEAT_W-1:0]         r_beat;
  logic [RAM_WIDTH-1:0]      r_pack;

  logic                      r_wr_enable;
  logic [PE_W-1:0]           r_wr_pe_id;
  logic [F_W-1:0]            r_wr_filter_id;
  logic [RAM_ADDR_WIDTH-1:0] r_wr_addr;
  logic [RAM_WIDTH-1:0]      r_wr_data;

  logic                      w_start;
  logic                      w_accept;
  logic                      w_word_end;
  logic                      w_last_word;
  logic [RAM_ADDR_WIDTH:0]   w_num_clamped;
  logic [RAM_ADDR_WIDTH:0]   w_last_off_full;
  logic [RAM_WIDTH-1:0]      w_word;

  assign w_start  = (r_state == S_IDLE) && i_start;
  assign w_accept = (r_state == S_LOAD) && i_valid;
  assign w_word_end = w_accept && (r_beat == LAST_BEAT);
  assign w_last_word = (r_offset == r_last_off) && (r_filter == LAST_FILTER) &&
                       (r_pe == LAST_PE);

  // Illegal word counts are clamped so the sequencer always terminates.
  always_comb begin
    w_num_clamped = i_num_words;
    if (i_num_words == '0) begin
      w_num_clamped = NW_ONE;
    end else if (i_num_words > NW_DEPTH) begin
      w_num_clamped = NW_DEPTH;
    end
  end

  assign w_last_off_full = w_num_clamped - NW_ONE;

  // Current beat merged into the partially packed word; first beat in LSBs.
  always_comb begin
    w_word = r_pack;
    w_word[r_beat*IN_WIDTH +: IN_WIDTH] = i_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_LOAD;
      S_LOAD: if (w_word_end && w_last_word) w_state_nxt = S_LAST;
      S_LAST: w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command latch, sequence counters and pack register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_base     <= '0;
      r_last_off <= '0;
      r_offset   <= '0;
      r_filter   <= '0;
      r_pe       <= '0;
      r_beat     <= '0;
      r_pack     <= '0;
    end else if (w_start) begin
      r_base     <= i_base_addr;
      r_last_off <= w_last_off_full[RAM_ADDR_WIDTH-1:0];
      r_offset   <= '0;
      r_filter   <= '0;
      r_pe       <= '0;
      r_beat     <= '0;
      r_pack     <= '0;
    end else if (w_accept) begin
      r_pack <= w_word;
      if (r_beat == LAST_BEAT) begin
        r_beat <= '0;
        if (r_offset == r_last_off) begin
          r_offset <= '0;
          if (r_filter == LAST_FILTER) begin
            r_filter <= '0;
            r_pe     <= r_pe + PE_W'(1);
          end else begin
            r_filter <= r_filter + F_W'(1);
          end
        end else begin
          r_offset <= r_offset + RAM_ADDR_WIDTH'(1);
        end
      end else begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  // Registered write request; fields hold between enables. The address sum
  // wraps naturally because RAM_DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_enable    <= 1'b0;
      r_wr_pe_id     <= '0;
      r_wr_filter_id <= '0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
    end else begin
      r_wr_enable <= w_word_end;
      if (w_word_end) begin
        r_wr_pe_id     <= r_pe;
        r_wr_filter_id <= r_filter;
        r_wr_addr      <= r_base + r_offset;
        r_wr_data      <= w_word;
      end
    end
  end

  assign o_ready        = (r_state == S_LOAD);
  assign o_busy         = (r_state == S_LOAD) || (r_state == S_LAST);
  assign o_done         = (r_state == S_DONE);
  assign o_wr_enable    = r_wr_enable;
  assign o_wr_pe_id     = r_wr_pe_id;
  assign o_wr_filter_id = r_wr_filter_id;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_data      = r_wr_data;

  a_num_words_legal : assert property (
    @(posedge clock) disable iff (reset)
    (r_state == S_IDLE && i_start) |-> (i_num_words != '0 && i_num_words <= NW_DEPTH)
  );

endmodule

// File: tb/tb_pe_filter_loader.sv
module tb_pe_filter_loader;

  localparam int NP    = 2;
  localparam int NF    = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 32;
  localparam int RW    = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW:0]   i_num_words = '0;
  logic [IW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          o_wr_enable;
  logic          o_wr_pe_id;
  logic          o_wr_filter_id;
  logic [AW-1:0] o_wr_addr;
  logic [RW-1:0] o_wr_data;
  logic          o_busy;
  logic          o_done;

  always #5 clock = ~clock;

  pe_filter_loader #(
    .NUM_PES(NP), .NUM_FILTERS(NF), .RAM_DEPTH(DEPTH),
    .RAM_ADDR_WIDTH(AW), .RAM_WIDTH(RW), .IN_WIDTH(IW)
  ) dut (
    .clock(clock), .reset(reset), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_num_words(i_num_words),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_wr_enable(o_wr_enable), .o_wr_pe_id(o_wr_pe_id),
    .o_wr_filter_id(o_wr_filter_id), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct packed {
    logic          pe;
    logic          f;
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every enable, checks latency and done.
  int  cyc = 0;
  int  last_en = -100;
  int  acc_cnt = 0;
  int  done_cnt = 0;
  bit  prev_acc = 1'b0;
  wr_t got;
  wr_t e_mon;

  always @(negedge clock) begin
    if (reset) begin
      acc_cnt  = 0;
      prev_acc = 1'b0;
    end else begin
      cyc++;
      if (o_wr_enable) begin
        got = {o_wr_pe_id, o_wr_filter_id, o_wr_addr, o_wr_data};
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", got, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check(got == e_mon, "write", got, e_mon);
        end
        check(prev_acc && (acc_cnt % 2 == 0), "wr_latency", {prev_acc, 32'(acc_cnt)}, 1);
        last_en = cyc;
      end
      if (o_done) begin
        done_cnt++;
        check((cyc - last_en == 1) && (exp_q.size() == 0), "done_timing",
              cyc - last_en, 1);
      end
      prev_acc = i_valid && o_ready;
      acc_cnt += int'(prev_acc);
    end
  end

  task automatic push_word(input int pe, input int f, input int addr, input int lo);
    wr_t e;
    e.pe   = 1'(pe);
    e.f    = 1'(f);
    e.addr = AW'(addr);
    e.data = {32'(lo + 1), 32'(lo)};
    exp_q.push_back(e);
  endtask

  task automatic push_load(input int base, input int nw, input int seed);
    for (int pe = 0; pe < NP; pe++)
      for (int f = 0; f < NF; f++)
        for (int off = 0; off < nw; off++)
          push_word(pe, f, (base + off) % DEPTH, seed + 2 * (((pe * NF) + f) * nw + off));
  endtask

  task automatic start_cmd(input int base, input int nw);
    @(posedge clock); #1;
    i_start = 1'b1; i_base_addr = AW'(base); i_num_words = (AW + 1)'(nw);
    @(posedge clock); #1;
    i_start = 1'b0;
    @(negedge clock);
    check(o_busy == 1'b1, "busy_rise", o_busy, 1);
  endtask

  // bp=1 gives the repeating valid pattern 1,0,0,1.
  task automatic drive(input int n, input int seed, input bit bp);
    int b = 0;
    int c = 0;
    while (b < n && c < 2000) begin
      @(posedge clock); #1;
      i_valid = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      i_data  = IW'(seed + b);
      @(negedge clock);
      if (i_valid && o_ready) b++;
      c++;
    end
    @(posedge clock); #1;
    i_valid = 1'b0;
    if (b < n) check(1'b0, "drive_timeout", b, n);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int c = 0;
    while (done_cnt == d0 && c < 500) begin
      @(negedge clock);
      c++;
    end
    if (done_cnt == d0) check(1'b0, "done_timeout", 0, 1);
    repeat (3) @(negedge clock);
    check((done_cnt - d0 == 1) && !o_busy, "done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check({o_ready, o_busy, o_done, o_wr_enable, o_wr_pe_id, o_wr_filter_id,
           o_wr_addr, o_wr_data} == '0, "reset_state",
          {o_ready, o_busy, o_done, o_wr_enable, o_wr_addr}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Valid in IDLE is not accepted.
    i_valid = 1'b1;
    i_data  = 32'hdead_beef;
    repeat (3) @(negedge clock);
    check(o_ready == 1'b0, "idle_not_ready", o_ready, 0);
    @(posedge clock); #1;
    i_valid = 1'b0;

    // Basic load.
    push_load(0, 2, 0);
    start_cmd(0, 2);
    drive(16, 0, 1'b0);
    wait_done();

    // Address wrap.
    push_load(15, 3, 1000);
    start_cmd(15, 3);
    drive(24, 1000, 1'b0);
    wait_done();

    // Source backpressure.
    push_load(0, 2, 0);
    start_cmd(0, 2);
    drive(16, 0, 1'b1);
    wait_done();

    // Start ignored while busy.
    push_load(0, 2, 200);
    start_cmd(0, 2);
    fork
      drive(16, 200, 1'b0);
      begin
        repeat (4) @(posedge clock);
        #2;
        i_start = 1'b1; i_base_addr = 4'd5; i_num_words = 5'd3;
        @(posedge clock); #2;
        i_start = 1'b0;
      end
    join
    wait_done();
    push_load(5, 1, 300);
    start_cmd(5, 1);
    drive(8, 300, 1'b0);
    wait_done();

    // Reset after 5 accepted beats: two full words written, half word dropped.
    push_word(0, 0, 0, 400);
    push_word(0, 0, 1, 402);
    start_cmd(0, 2);
    drive(5, 400, 1'b0);
    reset = 1'b1;
    #1;
    check({o_wr_enable, o_busy, o_ready} == 3'b000, "reset_abort",
          {o_wr_enable, o_busy, o_ready}, 0);
    check(exp_q.size() == 0, "reset_pending_writes", exp_q.size(), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    push_load(0, 2, 500);
    start_cmd(0, 2);
    drive(16, 500, 1'b0);
    wait_done();

    // Full depth.
    push_load(0, 16, 600);
    start_cmd(0, 16);
    drive(128, 600, 1'b0);
    wait_done();

    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_filter_loader.md
Name: pe_filter_loader

Overview:
- Sits directly upstream of the per-PE filter RAMs.
- Accepts a valid/ready stream of narrow filter beats from the DDR feeder and packs them into RAM_WIDTH-wide words.
- Drives the broadcast write-request bus (enable, pe_id, filter_id, addr, data) that every PE filter RAM snoops.
- Sequences one load command over all PEs, filters and addresses, then pulses done.

Parameters:
- NUM_PES, 4, number of PEs on the write bus; pe_id width PE_W = max(1, clog2(NUM_PES)).
- NUM_FILTERS, 4, filters per PE; filter_id width F_W = max(1, clog2(NUM_FILTERS)).
- RAM_DEPTH, 512, words per filter RAM; must be a power of two.
- RAM_ADDR_WIDTH, 9, log2(RAM_DEPTH).
- RAM_WIDTH, 256, filter RAM word width.
- IN_WIDTH, 64, input beat width; RAM_WIDTH must be an integer multiple; BEATS = RAM_WIDTH/IN_WIDTH.
- The pe_cfg_t values must match these parameters.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  command strobe; sampled only in IDLE.
- i_base_addr  in  RAM_ADDR_WIDTH  first RAM address written per filter.
- i_num_words  in  RAM_ADDR_WIDTH+1  words per filter, legal range 1..RAM_DEPTH.
- i_data  in  IN_WIDTH  filter beat.
- i_valid  in  1  beat valid.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- o_wr_enable  out  1  write-request enable.
- o_wr_pe_id  out  PE_W  target PE.
- o_wr_filter_id  out  F_W  target filter.
- o_wr_addr  out  RAM_ADDR_WIDTH  RAM address.
- o_wr_data  out  RAM_WIDTH  packed word.
- o_busy  out  1  high from command acceptance until done.
- o_done  out  1  one-cycle pulse after the final write is issued.

Behaviour:
- Reset (async assert) clears all outputs and state: state=IDLE, all o_* = 0, counters and pack register = 0.
- States:
  - IDLE: o_ready=0. On i_start, latch base and num_words, clear counters, go to LOAD, assert o_busy next cycle.
  - LOAD: o_ready=1 combinationally; stream may stall arbitrarily.
  - DONE: one cycle; o_done=1, o_busy=0 in that cycle; return to IDLE.
- i_start is ignored outside IDLE.
- i_num_words of 0 or greater than RAM_DEPTH is illegal. RTL must clamp 0 to 1 and values above RAM_DEPTH to RAM_DEPTH; simulation assertion fires on either.
- Packing: beat k of a word (k = 0..BEATS-1) lands in bits [k*IN_WIDTH +: IN_WIDTH]. The first beat is in the LSBs.
- Write issue: on acceptance of beat BEATS-1, the registered write request appears the next cycle with o_wr_enable=1 for exactly one cycle. Latency from last beat to enable = 1 cycle.
  - Enable is never held: back-to-back words give back-to-back single-cycle enables when BEATS=1.
- Sequence order: word offset fastest, then filter_id, then pe_id. Total writes = NUM_PES*NUM_FILTERS*num_words.
- Address: o_wr_addr = (base + offset) mod RAM_DEPTH. Wrap past RAM_DEPTH-1 to 0 is legal and silent.
- Counters: beat counter (0..BEATS-1), offset counter (0..num_words-1), filter counter, pe counter. All counters advance only on an accepted final beat, except the beat counter, which advances on every accepted beat.
- Final write: on acceptance of the final beat of the final word, o_ready drops in the next cycle. That cycle carries the last o_wr_enable. DONE follows in the cycle after, so o_done is 1 cycle after the last enable.
- When o_wr_enable=0, the o_wr_* fields hold their previous values; consumers must qualify on enable.
- Async reset mid-LOAD aborts the load: no further enables, the partial word is discarded, and the block returns to IDLE.
- i_valid while in IDLE or DONE is not accepted; data is not consumed.

Test Plan (NUM_PES=2, NUM_FILTERS=2, RAM_DEPTH=16, RAM_ADDR_WIDTH=4, IN_WIDTH=32, RAM_WIDTH=64):
- Basic load: start base=0, num_words=2, 16 beats continuously valid, beat i = i. Expect 8 enables in order (pe,filter,addr) = (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)...(1,1,1). First word data = 0x00000001_00000000. o_done exactly 1 cycle after the last enable.
- Wrap-around: base=15, num_words=3. Expect addresses 15,0,1 for each of the 4 (pe,filter) pairs; 12 enables total.
- Backpressure on source: i_valid toggles 1,0,0,1 pattern. Expect identical write sequence and data to the continuous case, each enable 1 cycle after the second beat of its word.
- Start ignored while busy: pulse i_start mid-load with base=5. Expect no change to the addresses of the ongoing load. After o_done, a new start is accepted and o_busy rises.
- Reset mid-load: assert reset after 5 accepted beats. Expect o_wr_enable, o_busy and o_ready = 0 immediately. A following full load from base=0 produces a clean first word with no stale half-word.
- Full depth: num_words=16. Expect 64 enables, addresses 0..15 per filter, o_done once.
